ray_fetch_unpacker: RTL and testbench

Fetches a job of 32-bit ray words from SDRAM through the `sdr_*` bulk-read bridge and delivers them one word per transfer to the intersector over a valid/ready stream. It splits the job into chunks of up to `CHUNK_WORDS` words and issues one bridge read per chunk. Each 2048-bit read result is latched and drained word-serially under downstream backpressure. It sits between the HPS-controlled read bridge and the ray intersector, and replaces the ad-hoc single-read test FSM.

---
 rtl/ray_fetch_unpacker.sv | 160 ++++++++++++++++
 tb/tb_ray_fetch_unpacker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_fetch_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : ray_fetch_unpacker
// Purpose  : Splits a ray job into bulk SDRAM reads and streams the words out.
// Options  : RAY_FETCH_STATS_EN adds busy/stall cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module ray_fetch_unpacker #(
    parameter int CHUNK_WORDS = 64
) (
    input  logic          sdr_clk,
    input  logic          sdr_reset,
    input  logic          start,
    input  logic [31:0]   base_addr,
    input  logic [29:0]   total_words,
    output logic          busy,
    output logic          done,
    output logic          sdr_readstart,
    output logic [31:0]   sdr_baseaddr,
    output logic [29:0]   sdr_nelems,
    input  logic [2047:0] sdr_readdata,
    input  logic          sdr_readend,
    output logic          word_valid,
    output logic [31:0]   word_data,
    output logic          word_last,
    input  logic          word_ready
`ifdef RAY_FETCH_STATS_EN
    ,
    output logic [31:0]   stat_busy_cycles,
    output logic [31:0]   stat_stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [29:0] c_chunk_max = 30'(CHUNK_WORDS);

    state_t         state_q, state_d;
    logic [31:0]    cur_addr_q, cur_addr_d;
    logic [29:0]    remaining_q, remaining_d;
    logic [29:0]    chunk_q, chunk_d;
    logic [5:0]     idx_q, idx_d;
    logic [2047:0]  buf_q, buf_d;

    logic [29:0]    w_chunk;
    logic           w_chunk_end;
    logic           w_in_req_wait;

    // remaining is frozen across REQ/WAIT, so the chunk size derived from it is stable there
    assign w_chunk       = (remaining_q < c_chunk_max) ? remaining_q : c_chunk_max;
    assign w_chunk_end   = ({24'd0, idx_q} == (chunk_q - 30'd1));
    assign w_in_req_wait = (state_q == S_REQ) || (state_q == S_WAIT);

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign sdr_readstart = (state_q == S_REQ);
    assign sdr_baseaddr  = w_in_req_wait ? cur_addr_q : 32'd0;
    assign sdr_nelems    = w_in_req_wait ? w_chunk : 30'd0;
    assign word_valid    = (state_q == S_DRAIN);
    assign word_data     = word_valid ? buf_q[{idx_q, 5'b00000} +: 32] : 32'd0;
    assign word_last     = word_valid && (remaining_q == 30'd1);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = total_words;
                    state_d     = (total_words != 30'd0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                chunk_d = w_chunk;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sdr_readend) begin
                    buf_d   = sdr_readdata;
                    idx_d   = 6'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (word_ready) begin
                    idx_d       = idx_q + 6'd1;
                    remaining_d = remaining_q - 30'd1;
                    if (w_chunk_end) begin
                        if (remaining_q != 30'd1) begin
                            cur_addr_d = cur_addr_q + {chunk_q, 2'b00};
                            state_d    = S_REQ;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sdr_clk) begin
        if (sdr_reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= 32'd0;
            remaining_q <= 30'd0;
            chunk_q     <= 30'd0;
            idx_q       <= 6'd0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
        end
    end

`ifdef RAY_FETCH_STATS_EN
    logic [31:0] busy_cnt_q;
    logic [31:0] stall_cnt_q;

    // Counters restart with each accepted job and stick at all-ones
    always_ff @(posedge sdr_clk) begin
        if (sdr_reset || ((state_q == S_IDLE) && start)) begin
            busy_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (busy && (busy_cnt_q != 32'hFFFF_FFFF)) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
            if (word_valid && !word_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stat_busy_cycles  = busy_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_fetch_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_fetch_unpacker
// Purpose  : Randomized scoreboard bench with a bridge model and job-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_fetch_unpacker;

    localparam int CHUNK = 64;

    logic          clk = 1'b0;
    logic          sdr_reset;
    logic          start;
    logic [31:0]   base_addr;
    logic [29:0]   total_words;
    logic          busy, done, sdr_readstart;
    logic [31:0]   sdr_baseaddr;
    logic [29:0]   sdr_nelems;
    logic [2047:0] sdr_readdata;
    logic          sdr_readend;
    logic          word_valid, word_last, word_ready;
    logic [31:0]   word_data;
`ifdef RAY_FETCH_STATS_EN
    logic [31:0]   stat_busy_cycles, stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    ray_fetch_unpacker #(.CHUNK_WORDS(CHUNK)) dut (
        .sdr_clk       (clk),
        .sdr_reset     (sdr_reset),
        .start         (start),
        .base_addr     (base_addr),
        .total_words   (total_words),
        .busy          (busy),
        .done          (done),
        .sdr_readstart (sdr_readstart),
        .sdr_baseaddr  (sdr_baseaddr),
        .sdr_nelems    (sdr_nelems),
        .sdr_readdata  (sdr_readdata),
        .sdr_readend   (sdr_readend),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_last     (word_last),
        .word_ready    (word_ready)
`ifdef RAY_FETCH_STATS_EN
        ,
        .stat_busy_cycles  (stat_busy_cycles),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_word_q[$];
    logic        exp_last_q[$];
    logic [31:0] exp_raddr_q[$];
    logic [29:0] exp_rn_q[$];

    int ready_mode = 0;
    int lat_max    = 0;
    bit stray_req  = 1'b0;
    int xfer_count = 0;
    int tb_busy    = 0;
    int tb_stall   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents are a pure function of the byte address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    function automatic logic [29:0] rnd30();
        logic [31:0] r;
        r = $urandom;
        return r[29:0];
    endfunction

    task automatic plan_job(input logic [31:0] base, input logic [29:0] n);
        int nn;
        nn = int'(n);
        for (int k = 0; k < nn; k++) begin
            exp_word_q.push_back(word_at(base + 32'(4 * k)));
            exp_last_q.push_back(k == nn - 1);
        end
        for (int off = 0; off < nn; off += CHUNK) begin
            exp_raddr_q.push_back(base + 32'(4 * off));
            exp_rn_q.push_back(30'((nn - off < CHUNK) ? (nn - off) : CHUNK));
        end
    endtask

    // Downstream ready pattern, changed just after each active edge
    initial begin
        int k;
        k = 0;
        word_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       word_ready = 1'b1;
                1:       word_ready = ($urandom_range(0, 1) == 1);
                default: word_ready = ((k % 4) == 0) || ((k % 4) == 3);
            endcase
            k++;
        end
    end

    // SDRAM bridge model
    initial begin
        logic [31:0]   a;
        logic [29:0]   n;
        logic [2047:0] d;
        int            lat;
        sdr_readend  = 1'b0;
        sdr_readdata = '0;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                stray_req = 1'b0;
                @(posedge clk);
                #1;
                sdr_readend = 1'b1;
                for (int i = 0; i < 64; i++) sdr_readdata[32*i +: 32] = $urandom;
                @(posedge clk);
                #1;
                sdr_readend = 1'b0;
            end else if (sdr_readstart && !sdr_reset) begin
                a = sdr_baseaddr;
                n = sdr_nelems;
                if (exp_raddr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got addr %0h n %0d expected no read", a, n);
                end else begin
                    check("read_addr", 64'(a), 64'(exp_raddr_q.pop_front()));
                    check("read_nelems", 64'(n), 64'(exp_rn_q.pop_front()));
                end
                for (int i = 0; i < 64; i++) begin
                    if (i < int'(n)) d[32*i +: 32] = word_at(a + 32'(4 * i));
                    else             d[32*i +: 32] = $urandom;
                end
                lat = $urandom_range(0, lat_max);
                repeat (lat) begin
                    @(negedge clk);
                    check("wait_addr_hold", 64'(sdr_baseaddr), 64'(a));
                    check("wait_n_hold", 64'(sdr_nelems), 64'(n));
                end
                @(posedge clk);
                #1;
                sdr_readend  = 1'b1;
                sdr_readdata = d;
                @(posedge clk);
                #1;
                sdr_readend  = 1'b0;
                sdr_readdata = {64{32'hDEAD_BEEF}};
                @(negedge clk);
                check("valid_after_readend", 64'(word_valid), 64'(1));
            end
        end
    end

    // Stream monitor / scoreboard
    initial begin
        bit          prev_stall, done_due, idle_due;
        logic [31:0] prev_data, ew;
        logic        prev_last, el;
        prev_stall = 0; done_due = 0; idle_due = 0;
        prev_data  = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (sdr_reset) begin
                prev_stall = 0; done_due = 0; idle_due = 0;
            end else begin
                if (idle_due) begin
                    check("idle_after_done", 64'({busy, done}), 64'(0));
                    idle_due = 0;
                end
                if (done_due) begin
                    check("done_after_last", 64'(done), 64'(1));
                    done_due = 0;
                    idle_due = 1;
                end
                if (prev_stall) begin
                    check("stall_valid_hold", 64'(word_valid), 64'(1));
                    check("stall_data_hold", 64'(word_data), 64'(prev_data));
                    check("stall_last_hold", 64'(word_last), 64'(prev_last));
                end
                if (busy) tb_busy++;
                if (word_valid && word_ready) begin
                    if (exp_word_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", word_data);
                    end else begin
                        ew = exp_word_q.pop_front();
                        el = exp_last_q.pop_front();
                        check("word_data", 64'(word_data), 64'(ew));
                        check("word_last", 64'(word_last), 64'(el));
                        xfer_count++;
                        if (el) done_due = 1;
                    end
                end
                if (word_valid && !word_ready) tb_stall++;
                prev_stall = word_valid && !word_ready;
                prev_data  = word_data;
                prev_last  = word_last;
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        check(name, 64'(|{busy, done, sdr_readstart, sdr_baseaddr, sdr_nelems,
                          word_valid, word_data, word_last}), 64'(0));
    endtask

    task automatic run_job(input logic [31:0] base, input logic [29:0] n, input bit junk);
        int cyc;
        plan_job(base, n);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = base; total_words = n;
        tb_busy = 0; tb_stall = 0;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = $urandom; total_words = rnd30();
        @(negedge clk);
        check("busy_at_T1", 64'(busy), 64'(1));
        check("readstart_at_T1", 64'(sdr_readstart), 64'(n != 30'd0));
        check("done_at_T1", 64'(done), 64'(n == 30'd0));
        cyc = 0;
        while (!done && cyc < 20000) begin
            start = junk && busy && ($urandom_range(0, 5) == 0);
            if (start) begin
                base_addr   = $urandom;
                total_words = rnd30();
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no done expected done within 20000 cycles");
        end
        @(negedge clk);
        check("words_left", 64'(exp_word_q.size()), 64'(0));
        check("reads_left", 64'(exp_raddr_q.size()), 64'(0));
        check("busy_after_job", 64'(busy), 64'(0));
`ifdef RAY_FETCH_STATS_EN
        check("stat_busy", 64'(stat_busy_cycles), 64'(tb_busy));
        check("stat_stall", 64'(stat_stall_cycles), 64'(tb_stall));
`endif
    endtask

    initial begin
        int cyc;
        logic [31:0] r;
        sdr_reset   = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        total_words = '0;
        repeat (3) @(posedge clk);
        #1;
        sdr_reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_outputs");

        ready_mode = 0; lat_max = 0;
        run_job(32'h0, 30'd15, 1'b0);
        run_job(32'h1000, 30'd130, 1'b0);

        ready_mode = 2; lat_max = 4;
        r = $urandom;
        run_job({r[31:2], 2'b00}, 30'd70, 1'b0);

        run_job(32'h0000_4000, 30'd0, 1'b0);

        // Reset in the middle of a 64-word chunk, then a stray read completion
        ready_mode = 0; lat_max = 2;
        plan_job(32'h0000_8000, 30'd64);
        xfer_count = 0;
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 32'h0000_8000; total_words = 30'd64;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (xfer_count < 5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (xfer_count < 5) begin
            checks++;
            errors++;
            $display("FAIL reset_job_timeout: got %0d words expected 5", xfer_count);
        end
        @(posedge clk);
        #1;
        sdr_reset = 1'b1;
        exp_word_q.delete(); exp_last_q.delete();
        exp_raddr_q.delete(); exp_rn_q.delete();
        @(posedge clk);
        #1;
        sdr_reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("midjob_reset_outputs");
        stray_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("stray_readend_ignored", 64'({busy, word_valid, done}), 64'(0));
        end
        run_job(32'h0000_0100, 30'd3, 1'b0);

        // Re-pulsed start while busy, random backpressure
        ready_mode = 1; lat_max = 6;
        run_job(32'h0002_0000, 30'd100, 1'b1);

        // Address wrap across 2^32
        run_job(32'hFFFF_FF00, 30'd130, 1'b1);

        for (int j = 0; j < 6; j++) begin
            r = $urandom;
            ready_mode = $urandom_range(0, 2);
            run_job({r[31:2], 2'b00}, 30'($urandom_range(1, 200)), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
